// File: rtl/mips_pkg.sv
// Shared MIPS definitions: syscall codes, special register indices and
// the write-back syscall FSM state type.
package mips_pkg;
    localparam logic [31:0] SYS_PRINT = 32'd1;
    localparam logic [31:0] SYS_EXIT  = 32'd10;
    localparam logic [4:0]  REG_V0    = 5'd2;
    localparam logic [4:0]  REG_A0    = 5'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRINT = 2'd1,
        HALT  = 2'd2
    } sys_state_t;
endpackage

// File: rtl/regfile_bypass.sv
// 32x32 register file: one write port, four combinational read ports,
// r0 hard-wired to zero, write-through bypass from the W-stage result.
module regfile_bypass (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        byp_en,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    input  logic [4:0]  ra4,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3,
    output logic [31:0] rd4
);
    logic [31:0] regs [32];

    function automatic logic [31:0] read_port(input logic [4:0]  a,
                                              input logic [31:0] arr_val,
                                              input logic        en,
                                              input logic [4:0]  waddr,
                                              input logic [31:0] wdata);
        if (a == 5'd0)
            return 32'd0;
        else if (en && (a == waddr))
            return wdata;
        else
            return arr_val;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Bypass follows regwrite alone so decode sees the W value this cycle.
    assign rd1 = read_port(ra1, regs[ra1], byp_en, wa, wd);
    assign rd2 = read_port(ra2, regs[ra2], byp_en, wa, wd);
    assign rd3 = read_port(ra3, regs[ra3], byp_en, wa, wd);
    assign rd4 = read_port(ra4, regs[ra4], byp_en, wa, wd);
endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: result mux, register file, and syscall servicing
// (console print with valid/ready, sticky exit, unsupported-code counter).
module wb_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] SYS_PRINT = mips_pkg::SYS_PRINT,
    parameter logic [31:0] SYS_EXIT  = mips_pkg::SYS_EXIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall_w,
    input  logic        regwrite_w,
    input  logic        memtoreg_w,
    input  logic [31:0] readdata_w,
    input  logic [31:0] aluout_w,
    input  logic [4:0]  writereg_w,
    input  logic [4:0]  ra1_d,
    input  logic [4:0]  ra2_d,
    output logic [31:0] rd1_d,
    output logic [31:0] rd2_d,
    output logic [31:0] result_w,
    output logic        stall_w,
    output logic        halt,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic [31:0] cons_data,
    output logic [7:0]  unsup_cnt
);
    sys_state_t  state;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        is_print;
    logic        is_exit;

    assign result_w = memtoreg_w ? readdata_w : aluout_w;

    regfile_bypass u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (regwrite_w && !halt),
        .byp_en (regwrite_w),
        .wa     (writereg_w),
        .wd     (result_w),
        .ra1    (ra1_d),
        .ra2    (ra2_d),
        .ra3    (REG_V0),
        .ra4    (REG_A0),
        .rd1    (rd1_d),
        .rd2    (rd2_d),
        .rd3    (v0),
        .rd4    (a0)
    );

    assign is_print = (v0 == SYS_PRINT);
    assign is_exit  = (v0 == SYS_EXIT);

    // Hold the pipeline until the syscall in W has been serviced.
    assign stall_w = ((state == IDLE) && syscall_w && (is_print || is_exit)) ||
                     ((state == PRINT) && !cons_ready) ||
                     (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cons_valid <= 1'b0;
            cons_data  <= 32'd0;
            halt       <= 1'b0;
            unsup_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (syscall_w) begin
                        if (is_print) begin
                            cons_data  <= a0;
                            cons_valid <= 1'b1;
                            state      <= PRINT;
                        end else if (is_exit) begin
                            halt  <= 1'b1;
                            state <= HALT;
                        end else if (unsup_cnt != 8'hFF) begin
                            unsup_cnt <= unsup_cnt + 8'd1;
                        end
                    end
                end
                PRINT: begin
                    if (cons_ready) begin
                        cons_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: register file, bypass, print/exit
// syscalls, unsupported-code saturation and reset during a pending print.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        syscall_w;
    logic        regwrite_w;
    logic        memtoreg_w;
    logic [31:0] readdata_w;
    logic [31:0] aluout_w;
    logic [4:0]  writereg_w;
    logic [4:0]  ra1_d;
    logic [4:0]  ra2_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [31:0] result_w;
    logic        stall_w;
    logic        halt;
    logic        cons_valid;
    logic        cons_ready;
    logic [31:0] cons_data;
    logic [7:0]  unsup_cnt;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    wb_stage #(.SYS_PRINT(32'd1), .SYS_EXIT(32'd10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .syscall_w  (syscall_w),
        .regwrite_w (regwrite_w),
        .memtoreg_w (memtoreg_w),
        .readdata_w (readdata_w),
        .aluout_w   (aluout_w),
        .writereg_w (writereg_w),
        .ra1_d      (ra1_d),
        .ra2_d      (ra2_d),
        .rd1_d      (rd1_d),
        .rd2_d      (rd2_d),
        .result_w   (result_w),
        .stall_w    (stall_w),
        .halt       (halt),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready),
        .cons_data  (cons_data),
        .unsup_cnt  (unsup_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && cons_valid && cons_ready)
            xfers <= xfers + 1;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; syscall_w = 1'b0; regwrite_w = 1'b0; memtoreg_w = 1'b0;
        readdata_w = 32'd0; aluout_w = 32'd0; writereg_w = 5'd0;
        ra1_d = 5'd0; ra2_d = 5'd0; cons_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        regwrite_w = 1'b1; memtoreg_w = 1'b0; writereg_w = r; aluout_w = v;
        @(negedge clk);
        regwrite_w = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        do_reset();
        ra1_d = 5'd5; ra2_d = 5'd31;
        #1;
        checks++; if (rd1_d !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want 0", rd1_d); end
        checks++; if (rd2_d !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want 0", rd2_d); end
        checks++; if ({stall_w, halt, cons_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {stall_w, halt, cons_valid}); end
        checks++; if (cons_data !== 32'd0) begin errors++; $display("FAIL reset_cons_data got %h want 0", cons_data); end
        checks++; if (unsup_cnt !== 8'd0) begin errors++; $display("FAIL reset_unsup got %0d want 0", unsup_cnt); end
    endtask

    task automatic test_regfile();
        write_reg(5'd5, 32'hDEADBEEF);
        ra1_d = 5'd5;
        #1;
        checks++; if (rd1_d !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_read5 got %h want deadbeef", rd1_d); end
        @(negedge clk);
        regwrite_w = 1'b1; writereg_w = 5'd0; aluout_w = 32'hFFFF_FFFF; ra2_d = 5'd0;
        #1;
        checks++; if (rd2_d !== 32'd0) begin errors++; $display("FAIL rf_r0_bypass got %h want 0", rd2_d); end
        checks++; if (result_w !== 32'hFFFF_FFFF) begin errors++; $display("FAIL result_alu got %h want ffffffff", result_w); end
        @(negedge clk);
        regwrite_w = 1'b0;
        #1;
        checks++; if (rd2_d !== 32'd0) begin errors++; $display("FAIL rf_r0_array got %h want 0", rd2_d); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        regwrite_w = 1'b1; writereg_w = 5'd7; memtoreg_w = 1'b1;
        readdata_w = 32'h1234; aluout_w = 32'h5555; ra2_d = 5'd7; ra1_d = 5'd5;
        #1;
        checks++; if (result_w !== 32'h1234) begin errors++; $display("FAIL result_mem got %h want 1234", result_w); end
        checks++; if (rd2_d !== 32'h1234) begin errors++; $display("FAIL bypass_rd2 got %h want 1234", rd2_d); end
        checks++; if (rd1_d !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other got %h want deadbeef", rd1_d); end
        @(negedge clk);
        regwrite_w = 1'b0; memtoreg_w = 1'b0; readdata_w = 32'd0;
        #1;
        checks++; if (rd2_d !== 32'h1234) begin errors++; $display("FAIL bypass_array got %h want 1234", rd2_d); end
    endtask

    task automatic test_print();
        int stall_hi;
        int x0;
        stall_hi = 0;
        write_reg(5'd2, 32'd1);
        x0 = xfers;
        // $a0 reaches the syscall only through the bypass in the same cycle.
        @(negedge clk);
        syscall_w = 1'b1; cons_ready = 1'b0;
        regwrite_w = 1'b1; writereg_w = 5'd4; aluout_w = 32'd42;
        #1;
        if (stall_w) stall_hi++;
        checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL print_early_valid got %b want 0", cons_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            syscall_w = 1'b0; regwrite_w = 1'b0;
            #1;
            if (stall_w) stall_hi++;
            checks++; if (cons_valid !== 1'b1 || cons_data !== 32'd42) begin errors++; $display("FAIL print_wait%0d got valid=%b data=%0d want 1/42", i, cons_valid, cons_data); end
        end
        @(negedge clk);
        cons_ready = 1'b1;
        #1;
        checks++; if (stall_hi !== 4) begin errors++; $display("FAIL print_stall_cycles got %0d want 4", stall_hi); end
        checks++; if (stall_w !== 1'b0 || cons_valid !== 1'b1) begin errors++; $display("FAIL print_accept got stall=%b valid=%b want 0/1", stall_w, cons_valid); end
        @(negedge clk);
        cons_ready = 1'b0;
        #1;
        checks++; if (cons_valid !== 1'b0 || stall_w !== 1'b0) begin errors++; $display("FAIL print_done got valid=%b stall=%b want 0/0", cons_valid, stall_w); end
        checks++; if (xfers - x0 !== 1) begin errors++; $display("FAIL print_xfers got %0d want 1", xfers - x0); end
        ra1_d = 5'd4;
        #1;
        checks++; if (rd1_d !== 32'd42) begin errors++; $display("FAIL print_a0_written got %0d want 42", rd1_d); end
    endtask

    task automatic test_unsupported();
        logic stall_seen;
        stall_seen = 1'b0;
        write_reg(5'd2, 32'd99);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            syscall_w = 1'b1;
            #1;
            if (stall_w) stall_seen = 1'b1;
            if (i == 10) begin
                checks++; if (unsup_cnt !== 8'd10) begin errors++; $display("FAIL unsup_mid got %0d want 10", unsup_cnt); end
            end
            @(negedge clk);
            syscall_w = 1'b0;
        end
        #1;
        checks++; if (unsup_cnt !== 8'd255) begin errors++; $display("FAIL unsup_sat got %0d want 255", unsup_cnt); end
        checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL unsup_stall got %b want 0", stall_seen); end
    endtask

    task automatic test_midprint_reset();
        write_reg(5'd2, 32'd1);
        write_reg(5'd4, 32'd77);
        @(negedge clk);
        syscall_w = 1'b1; cons_ready = 1'b0;
        @(negedge clk);
        syscall_w = 1'b0;
        #1;
        checks++; if (cons_valid !== 1'b1 || cons_data !== 32'd77) begin errors++; $display("FAIL mid_pre got valid=%b data=%0d want 1/77", cons_valid, cons_data); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ra1_d = 5'd4;
        #1;
        checks++; if (cons_valid !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL mid_ctrl got valid=%b halt=%b want 0/0", cons_valid, halt); end
        checks++; if (rd1_d !== 32'd0) begin errors++; $display("FAIL mid_a0 got %0d want 0", rd1_d); end
        checks++; if (stall_w !== 1'b0 || unsup_cnt !== 8'd0) begin errors++; $display("FAIL mid_idle got stall=%b unsup=%0d want 0/0", stall_w, unsup_cnt); end
    endtask

    task automatic test_exit();
        write_reg(5'd3, 32'h33);
        write_reg(5'd2, 32'd10);
        @(negedge clk);
        syscall_w = 1'b1;
        #1;
        checks++; if (stall_w !== 1'b1 || halt !== 1'b0) begin errors++; $display("FAIL exit_n got stall=%b halt=%b want 1/0", stall_w, halt); end
        @(negedge clk);
        syscall_w = 1'b0;
        #1;
        checks++; if (stall_w !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL exit_n1 got stall=%b halt=%b want 1/1", stall_w, halt); end
        @(negedge clk);
        regwrite_w = 1'b1; memtoreg_w = 1'b0; writereg_w = 5'd3; aluout_w = 32'h77;
        @(negedge clk);
        regwrite_w = 1'b0; ra1_d = 5'd3;
        #1;
        checks++; if (rd1_d !== 32'h33) begin errors++; $display("FAIL exit_nowrite got %h want 33", rd1_d); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall_w !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL exit_sticky got stall=%b halt=%b want 1/1", stall_w, halt); end
        do_reset();
        #1;
        checks++; if (halt !== 1'b0 || stall_w !== 1'b0) begin errors++; $display("FAIL exit_reset got halt=%b stall=%b want 0/0", halt, stall_w); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_bypass();
        test_print();
        test_unsupported();
        test_midprint_reset();
        test_exit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the MIPS pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back result. It owns the 32×32 register file, which has two decode read ports and internal write-through bypass. It also executes `syscall` when that instruction reaches W: print-integer goes out through a valid/ready console port, and exit latches a sticky halt. While either syscall is outstanding, the block freezes the pipeline.

## Interface
Parameters:
- `SYS_PRINT`, default 1: `$v0` code for print-integer.
- `SYS_EXIT`, default 10: `$v0` code for exit.

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `syscall_w`, in, 1: instruction in W is `syscall`.
- `regwrite_w`, in, 1: instruction in W writes a register.
- `memtoreg_w`, in, 1: 1 = write back `readdata_w`; 0 = write back `aluout_w`.
- `readdata_w`, in, 32: load data from data memory.
- `aluout_w`, in, 32: ALU result.
- `writereg_w`, in, 5: destination register.
- `ra1_d`, in, 5: decode read address, port 1.
- `ra2_d`, in, 5: decode read address, port 2.
- `rd1_d`, out, 32: read data, port 1.
- `rd2_d`, out, 32: read data, port 2.
- `result_w`, out, 32: selected write-back value; also used for forwarding to E.
- `stall_w`, out, 1: freeze all pipeline registers, including MEM/WB.
- `halt`, out, 1: sticky program exit.
- `cons_valid`, out, 1: console data valid.
- `cons_ready`, in, 1: console accepts the data.
- `cons_data`, out, 32: integer to print.
- `unsup_cnt`, out, 8: count of unsupported syscall codes; saturates.

## Operation
- `result_w = memtoreg_w ? readdata_w : aluout_w`. This is combinational.
- Register write:
  - Occurs at posedge when `regwrite_w && writereg_w != 0 && !halt`.
  - `$0` always reads 0.
  - A write still happens during `stall_w`. It is idempotent because the inputs are held.
- Reads are combinational. If the read address equals `writereg_w`, `regwrite_w=1` and the address is non-zero, the read returns `result_w` (write-through bypass).
- Internal reads of `$v0` (r2) and `$a0` (r4) use the same bypass rule.
- Syscall FSM states:
  - IDLE:
    - `syscall_w=1` and `v0==SYS_PRINT`: capture `a0` into `cons_data`; go to PRINT.
    - `syscall_w=1` and `v0==SYS_EXIT`: go to HALT.
    - `syscall_w=1` and any other `v0`: increment `unsup_cnt`, saturating at 255; stay in IDLE.
  - PRINT: `cons_valid=1`. On `cons_valid && cons_ready`, go to IDLE. `syscall_w` is ignored in this state.
  - HALT: terminal; only reset leaves it. `halt=1`; register writes are suppressed.
- `stall_w` is combinational:
  - asserted when state is IDLE, `syscall_w=1` and `v0` is SYS_PRINT or SYS_EXIT;
  - asserted when state is PRINT and `cons_ready=0`;
  - asserted when state is HALT.
- Because of this, the `syscall` instruction stays in W until it has been serviced. The next instruction enters W on the same edge as the handshake.
- When `syscall_w` and `regwrite_w` are both set, the write still happens. The syscall samples `$v0` and `$a0` with the bypass applied.

## Timing
- Reset values: all registers 0, state IDLE, `cons_valid=0`, `cons_data=0`, `halt=0`, `unsup_cnt=0`.
- `stall_w` is low after reset unless its combinational terms are true.
- `rst_n` low in any state, including mid-PRINT, forces these values at the next posedge. A pending print is dropped.
- Write latency: the value is visible through the array one cycle after the write edge. It is visible the same cycle through the bypass.
- Print latency:
  - `syscall_w` in cycle N gives `cons_valid` in cycle N+1.
  - `cons_data` is stable while `cons_valid` is high.
  - The minimum occupancy of W by the syscall is 2 cycles: N plus the accept cycle.
- Exit: `syscall_w` in cycle N gives `halt=1` from N+1 onward. `stall_w` is high from N onward.
- `cons_ready` is allowed to be high before `cons_valid`. Transfer occurs only on cycles where both are high.

## Structure
- Shared package `mips_pkg`:
  - syscall codes `SYS_PRINT=1` and `SYS_EXIT=10`;
  - register indices `REG_V0=2` and `REG_A0=4`;
  - the state enum `sys_state_t` {IDLE, PRINT, HALT}.
- Sub-module `regfile_bypass`: 32×32 array with 1 write port, 4 combinational read ports (`ra1_d`, `ra2_d`, `$v0`, `$a0`), r0 forced to zero, and bypass.
- The top level holds the result mux, the syscall FSM, the console register and the counter.

## Test plan
- Reset, then write `$5=0xDEADBEEF` via `aluout_w` (`memtoreg_w=0`). Next cycle `ra1_d=5` gives `rd1_d=0xDEADBEEF`. A write to `$0` leaves `rd2_d=0` for `ra2_d=0`.
- Bypass: `regwrite_w=1`, `writereg_w=7`, `memtoreg_w=1`, `readdata_w=0x1234`, with `ra2_d=7` in the same cycle. Then `rd2_d=0x1234`.
- Print: `$v0=1`, `$a0=42`, then `syscall_w` for one cycle with `cons_ready` held low for 3 cycles.
  - `stall_w` is high for 4 cycles.
  - `cons_valid=1` with `cons_data=42` until accept.
  - After accept, state returns to IDLE and exactly one transfer has occurred.
- Exit: `$v0=10`, then `syscall_w`.
  - `halt` rises the next cycle and stays high; `stall_w` stays high.
  - A later `regwrite_w` to `$3` does not change `$3`.
- Unsupported: `$v0=99`, `syscall_w` for 300 separate cycles. `unsup_cnt=255` and `stall_w` is never asserted.
- Mid-print reset: with the FSM in PRINT and `cons_ready=0`, assert `rst_n=0` for one cycle. Then `cons_valid=0`, `halt=0`, `$a0=0`, and the state is IDLE.
